seg_dynamic_scan: RTL and testbench



---
 rtl/seg_dynamic_pkg.sv | 33 +++
 rtl/seg_dynamic_scan_bin2bcd.sv | 28 ++
 rtl/seg_dynamic_scan.sv | 119 +++++++++++
 tb/tb_seg_dynamic_scan.sv | 131 +++++++++++++
 4 files changed

// File: rtl/seg_dynamic_pkg.sv
// Shared constants for the 6-digit multiplexed 7-segment driver:
// digit count, input clamp value, special digit codes and the
// active-low segment pattern table (bit7 = dp, bits6..0 = g..a).
package seg_dynamic_pkg;

    localparam int          NUM_DIGITS = 6;
    localparam logic [19:0] DATA_MAX   = 20'd999999;

    localparam logic [3:0]  CODE_BLANK = 4'd10;
    localparam logic [3:0]  CODE_MINUS = 4'd11;

    // What a scanned position displays.
    typedef enum logic [1:0] {
        DIG_NUM   = 2'd0,
        DIG_MINUS = 2'd1,
        DIG_BLANK = 2'd2
    } digit_kind_t;

    // Indexed by digit code; entries 12..15 are unused and stay dark.
    localparam logic [15:0][7:0] SEG_TABLE = {
        8'hFF, 8'hFF, 8'hFF, 8'hFF,   // 15..12
        8'hBF,                        // 11 minus
        8'hFF,                        // 10 blank
        8'h90, 8'h80, 8'hF8, 8'h82,   // 9..6
        8'h92, 8'h99, 8'hB0, 8'hA4,   // 5..2
        8'hF9, 8'hC0                  // 1..0
    };

    function automatic logic [7:0] seg_pattern(input logic [3:0] code);
        return SEG_TABLE[code];
    endfunction

endpackage

// File: rtl/seg_dynamic_scan_bin2bcd.sv
// Combinational double-dabble: 20-bit binary to six packed BCD digits
// (digit 0 in bits 3:0). Input must already be clamped to 999999 so the
// result fits in six digits.
module bin2bcd
    import seg_dynamic_pkg::*;
(
    input  logic [19:0] i_bin,
    output logic [23:0] o_bcd
);

    logic [43:0] w_shift;

    // Shift-and-add-3: correct each BCD nibble before every left shift.
    always_comb begin
        w_shift = {24'd0, i_bin};
        for (int s = 0; s < 20; s++) begin
            for (int d = 0; d < NUM_DIGITS; d++) begin
                if (w_shift[20 + 4*d +: 4] >= 4'd5) begin
                    w_shift[20 + 4*d +: 4] = w_shift[20 + 4*d +: 4] + 4'd3;
                end
            end
            w_shift = w_shift << 1;
        end
    end

    assign o_bcd = w_shift[43:20];

endmodule

// File: rtl/seg_dynamic_scan.sv
// 6-digit multiplexed 7-segment display driver.
// Clamps the binary input, converts it to BCD (registered), blanks leading
// zeros, places a minus sign left of the highest shown digit and scans one
// digit per CNT_SEG_MAX+1 clocks. seg/sel are registered.
// Build option: define SEG_COMMON_CATHODE_EN to invert seg and sel
// (seg active-high, sel active-low).
module seg_dynamic_scan
    import seg_dynamic_pkg::*;
#(
    parameter logic [15:0] CNT_SEG_MAX = 16'd49999
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [19:0] data,
    input  logic [5:0]  point,
    input  logic        sign,
    input  logic        seg_en,
    output logic [7:0]  seg,
    output logic [5:0]  sel
);

    logic [15:0]  r_cnt;
    logic [2:0]   r_idx;
    logic [23:0]  r_bcd;
    logic [7:0]   r_seg;
    logic [5:0]   r_sel;

    logic [19:0]  w_clamped;
    logic [23:0]  w_bcd;
    logic [2:0]   w_top;
    logic [3:0]   w_digit;
    digit_kind_t  w_kind;
    logic [7:0]   w_seg_next;

    assign w_clamped = (data > DATA_MAX) ? DATA_MAX : data;

    bin2bcd u_bin2bcd (
        .i_bin (w_clamped),
        .o_bcd (w_bcd)
    );

    // Dwell counter and digit index; they run regardless of seg_en so
    // re-enabling keeps the frame timing intact.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (r_cnt >= CNT_SEG_MAX) begin
            r_cnt <= '0;
            r_idx <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    // Register the BCD conversion result.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_bcd <= '0;
        end else begin
            r_bcd <= w_bcd;
        end
    end

    // Highest shown position: most significant nonzero digit or highest dp bit.
    always_comb begin
        w_top = 3'd0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if (r_bcd[4*i +: 4] != 4'd0 || point[i]) begin
                w_top = 3'(i);
            end
        end
    end

    assign w_digit = r_bcd[{r_idx, 2'b00} +: 4];

    // Classify the current position as numeric, minus or blank.
    always_comb begin
        w_kind = DIG_BLANK;
        if (r_idx <= w_top) begin
            w_kind = DIG_NUM;
        end else if (sign && (w_top != 3'd5) && (r_idx == w_top + 3'd1)) begin
            w_kind = DIG_MINUS;
        end
    end

    // Segment pattern; dp only ever lights on a numeric digit.
    always_comb begin
        w_seg_next = seg_pattern(CODE_BLANK);
        case (w_kind)
            DIG_NUM:   w_seg_next = seg_pattern(w_digit) & {~point[r_idx], 7'h7F};
            DIG_MINUS: w_seg_next = seg_pattern(CODE_MINUS);
            default:   w_seg_next = seg_pattern(CODE_BLANK);
        endcase
    end

    // Output registers; disabled display is fully dark from the next clock.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_seg <= 8'hFF;
            r_sel <= 6'b000000;
        end else if (!seg_en) begin
            r_seg <= 8'hFF;
            r_sel <= 6'b000000;
        end else begin
            r_seg <= w_seg_next;
            r_sel <= 6'b000001 << r_idx;
        end
    end

`ifdef SEG_COMMON_CATHODE_EN
    assign seg = ~r_seg;
    assign sel = ~r_sel;
`else
    assign seg = r_seg;
    assign sel = r_sel;
`endif

endmodule

// File: tb/tb_seg_dynamic_scan.sv
module tb_seg_dynamic_scan;

    localparam logic [15:0] CNT = 16'd49;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [19:0] data;
    logic [5:0]  point;
    logic        sign;
    logic        seg_en;
    logic [7:0]  seg;
    logic [5:0]  sel;

    int total = 0;
    int bad   = 0;

    seg_dynamic_scan #(.CNT_SEG_MAX(CNT)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .data    (data),
        .point   (point),
        .sign    (sign),
        .seg_en  (seg_en),
        .seg     (seg),
        .sel     (sel)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic wait_sel(input logic [5:0] t);
        int n;
        n = 0;
        while (sel !== t && n < 400) begin
            @(negedge sys_clk);
            n++;
        end
        if (sel !== t) chk("sel_timeout", {2'b00, sel}, {2'b00, t});
    endtask

    // exp = {d5,d4,d3,d2,d1,d0}
    task automatic check_frame(input string tag, input logic [47:0] exp);
        logic [5:0] oh;
        tick(3);
        for (int d = 0; d < 6; d++) begin
            oh = 6'b000001 << d;
            wait_sel(oh);
            chk($sformatf("%s_d%0d", tag, d), seg, exp[8*d +: 8]);
        end
    endtask

    task automatic apply(input logic [19:0] v, input logic [5:0] p, input logic s,
                         input string tag, input logic [47:0] exp);
        data  = v;
        point = p;
        sign  = s;
        check_frame(tag, exp);
    endtask

    initial begin
        logic [5:0] oh;
        sys_rst = 1'b1;
        data    = 20'd0;
        point   = 6'b000000;
        sign    = 1'b0;
        seg_en  = 1'b1;

        @(negedge sys_clk);
        chk("rst_sel", {2'b00, sel}, 8'h00);
        chk("rst_seg", seg, 8'hFF);
        sys_rst = 1'b0;

        // first negedge after release: edge 1
        @(negedge sys_clk);
        chk("zero_d0_seg", seg, 8'hC0);
        for (int k = 0; k < 7; k++) begin
            oh = 6'b000001 << (k % 6);
            chk($sformatf("scan_first_%0d", k), {2'b00, sel}, {2'b00, oh});
            tick(49);
            chk($sformatf("scan_last_%0d", k), {2'b00, sel}, {2'b00, oh});
            tick(1);
        end

        apply(20'd999999, 6'b000010, 1'b0, "all9",     48'h90_90_90_90_10_90);
        apply(20'd87654,  6'b000010, 1'b1, "neg87654", 48'hBF_80_F8_82_12_99);
        apply(20'd12345,  6'b001000, 1'b0, "p12345",   48'hFF_F9_24_B0_99_92);
        apply(20'd5,      6'b000000, 1'b0, "five",     48'hFF_FF_FF_FF_FF_92);
        apply(20'd5,      6'b000000, 1'b1, "negfive",  48'hFF_FF_FF_FF_BF_92);
        apply(20'd0,      6'b000000, 1'b1, "negzero",  48'hFF_FF_FF_FF_BF_C0);
        apply(20'd123456, 6'b000000, 1'b1, "nosign",   48'hF9_A4_B0_99_92_82);
        apply(20'd5,      6'b000100, 1'b0, "fivedp",   48'hFF_FF_FF_40_C0_92);
        apply(20'd1048575,6'b000100, 1'b0, "clamp",    48'h90_90_90_10_90_90);

        // enable/disable with scan timing check
        apply(20'd12345,  6'b000000, 1'b0, "pre_en",   48'hFF_F9_A4_B0_99_92);
        wait_sel(6'b000010);
        wait_sel(6'b000100);
        tick(10);
        seg_en = 1'b0;
        tick(1);
        chk("dis_sel", {2'b00, sel}, 8'h00);
        chk("dis_seg", seg, 8'hFF);
        tick(58);
        chk("dis_hold_sel", {2'b00, sel}, 8'h00);
        tick(1);
        seg_en = 1'b1;
        tick(1);
        chk("reen_sel", {2'b00, sel}, 8'h08);
        chk("reen_seg", seg, 8'hA4);
        tick(28);
        chk("reen_last_sel", {2'b00, sel}, 8'h08);
        tick(1);
        chk("reen_next_sel", {2'b00, sel}, 8'h10);
        chk("reen_next_seg", seg, 8'hF9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
